// File: rtl/rf_wb_seq_pkg.sv
// Shared register-file definitions for the 4x16b register file and its write-back sequencer.
package rf_wb_seq_pkg;

  localparam int unsigned RF_WIDTH    = 16;
  localparam int unsigned RF_NREGS    = 4;
  localparam int unsigned RF_AW       = 2;
  localparam int unsigned WB_DEPTH    = 4;

  // Saturation value of a per-register pending-write counter.
  localparam logic [1:0]  PEND_MAX    = 2'd3;

  // Write-back entry layout, most significant field first.
  typedef struct packed {
    logic [RF_AW-1:0]    rd;
    logic [RF_WIDTH-1:0] data;
  } wb_entry_t;

  // Round-robin priority between the two result producers.
  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LD  = 1'b1
  } prio_e;

endpackage

// File: rtl/rf_wb_seq_fifo.sv
// Synchronous write-back FIFO with wrap-around pointers and an occupancy count.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned  PW       = $clog2(DEPTH);
  localparam logic [PW:0]  FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_seq.sv
// Register-file write-back sequencer: arbitrates ALU/load results into a FIFO,
// retires one entry per cycle onto the RF write port and tracks pending writes.
module rf_wb_seq
  import rf_wb_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned NREGISTERS = RF_NREGS,
  parameter int unsigned AW         = RF_AW,
  parameter int unsigned DEPTH      = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_vld,
  input  logic [AW-1:0]         alu_rd,
  input  logic [WIDTH-1:0]      alu_data,
  output logic                  alu_rdy,
  input  logic                  ld_vld,
  input  logic [AW-1:0]         ld_rd,
  input  logic [WIDTH-1:0]      ld_data,
  output logic                  ld_rdy,
  input  logic                  iss_vld,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_rdy,
  output logic [NREGISTERS-1:0] busy,
  output logic [AW-1:0]         wb_rd,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  wb_en,
  inout  wire                   dvdd,
  inout  wire                   dgnd
);

  prio_e                  r_rr;
  logic                   r_wb_en;
  logic [AW-1:0]          r_wb_rd;
  logic [WIDTH-1:0]       r_wb_data;
  logic [1:0]             r_pend [NREGISTERS];

  logic                   w_grant_alu;
  logic                   w_grant_ld;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic [AW+WIDTH-1:0]    w_push_entry;
  logic [AW+WIDTH-1:0]    w_head;
  logic [$clog2(DEPTH):0] w_unused_count;
  logic                   w_claim;
  logic [NREGISTERS-1:0]  w_inc;
  logic [NREGISTERS-1:0]  w_dec;
  logic                   w_unused_pwr;

  // Power pins carry no logic.
  assign w_unused_pwr = dvdd ^ dgnd;

  assign w_grant_alu  = alu_vld & (~ld_vld | (r_rr == PRIO_ALU));
  assign w_grant_ld   = ld_vld & ~w_grant_alu;
  assign alu_rdy      = w_grant_alu & ~w_full;
  assign ld_rdy       = w_grant_ld & ~w_full;
  assign w_push       = alu_rdy | ld_rdy;
  assign w_push_entry = w_grant_alu ? {alu_rd, alu_data} : {ld_rd, ld_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (~w_empty),
    .o_data  (w_head),
    .o_count (w_unused_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Round-robin: only a contested, accepted push hands priority to the loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= PRIO_ALU;
    end else if (w_push & alu_vld & ld_vld) begin
      r_rr <= w_grant_alu ? PRIO_LD : PRIO_ALU;
    end
  end

  // Retire the FIFO head each cycle it is non-empty; rd/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (!w_empty) begin
      r_wb_en              <= 1'b1;
      {r_wb_rd, r_wb_data} <= w_head;
    end else begin
      r_wb_en <= 1'b0;
    end
  end

  assign wb_en   = r_wb_en;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;

  // A claim may still enter a saturated counter when that register commits this cycle.
  assign iss_rdy = (r_pend[iss_rd] != PEND_MAX) | (r_wb_en & (r_wb_rd == iss_rd));
  assign w_claim = iss_vld & iss_rdy;
  assign w_inc   = w_claim ? (NREGISTERS'(1) << iss_rd) : '0;
  assign w_dec   = r_wb_en ? (NREGISTERS'(1) << r_wb_rd) : '0;

  // Pending-write counters: +1 on claim, -1 on RF commit, no underflow below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGISTERS; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGISTERS; i++) begin
        if (w_inc[i] & ~w_dec[i]) begin
          r_pend[i] <= r_pend[i] + 1'b1;
        end else if (w_dec[i] & ~w_inc[i] & (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  // Busy flags mirror non-zero pending counts.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NREGISTERS; i++) begin
      busy[i] = (r_pend[i] != '0);
    end
  end

endmodule

// File: tb/tb_rf_wb_seq.sv
// Directed self-checking bench for rf_wb_seq.
module tb_rf_wb_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld, ld_vld, iss_vld;
  logic [1:0]  alu_rd, ld_rd, iss_rd;
  logic [15:0] alu_data, ld_data;
  logic        alu_rdy, ld_rdy, iss_rdy;
  logic [3:0]  busy;
  logic [1:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_en;
  wire         dvdd = 1'b1;
  wire         dgnd = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [17:0] log_q [$];

  rf_wb_seq #(
    .WIDTH      (16),
    .NREGISTERS (4),
    .AW         (2),
    .DEPTH      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_vld  (alu_vld),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_rdy  (alu_rdy),
    .ld_vld   (ld_vld),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .ld_rdy   (ld_rdy),
    .iss_vld  (iss_vld),
    .iss_rd   (iss_rd),
    .iss_rdy  (iss_rdy),
    .busy     (busy),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_en    (wb_en),
    .dvdd     (dvdd),
    .dgnd     (dgnd)
  );

  always #5 clk = ~clk;

  // Record every retired write, sampled mid-cycle.
  always @(negedge clk) begin
    if (wb_en === 1'b1) log_q.push_back({wb_rd, wb_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_vld = 1'b0;
    ld_vld  = 1'b0;
    iss_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0;
    n_chk++; if (wb_en !== 1'b0) $display("FAIL rst_wb_en got=%b exp=0", wb_en); else n_pass++;
    n_chk++; if (wb_rd !== 2'd0) $display("FAIL rst_wb_rd got=%h exp=0", wb_rd); else n_pass++;
    n_chk++; if (wb_data !== 16'h0000) $display("FAIL rst_wb_data got=%h exp=0000", wb_data); else n_pass++;
    n_chk++; if (busy !== 4'b0000) $display("FAIL rst_busy got=%b exp=0000", busy); else n_pass++;
    // Mid-stream traffic with claims and pushes, then reset for two cycles while still driving.
    for (int i = 0; i < 3; i++) begin
      iss_vld = 1'b1; iss_rd = 2'(i);
      alu_vld = 1'b1; alu_rd = 2'(i); alu_data = 16'(16'h1110 + i);
      tick();
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; idle();
    #1;
    n_chk++; if (wb_en !== 1'b0) $display("FAIL rst_mid_wb_en got=%b exp=0", wb_en); else n_pass++;
    n_chk++; if (busy !== 4'b0000) $display("FAIL rst_mid_busy got=%b exp=0000", busy); else n_pass++;
    alu_vld = 1'b1; #1;
    n_chk++; if (alu_rdy !== 1'b1) $display("FAIL rst_alu_rdy got=%b exp=1", alu_rdy); else n_pass++;
    alu_vld = 1'b1; ld_vld = 1'b1; #1;
    n_chk++; if ({alu_rdy, ld_rdy} !== 2'b10) $display("FAIL rst_rr_prio got=%b exp=10", {alu_rdy, ld_rdy}); else n_pass++;
    alu_vld = 1'b0; ld_vld = 1'b1; #1;
    n_chk++; if (ld_rdy !== 1'b1) $display("FAIL rst_ld_rdy got=%b exp=1", ld_rdy); else n_pass++;
    idle();
    tick();
    n_chk++; if (wb_en !== 1'b0) $display("FAIL rst_flushed got=%b exp=0", wb_en); else n_pass++;
    tick();
  endtask

  task automatic test_single_write();
    log_q.delete();
    iss_vld = 1'b1; iss_rd = 2'd2;
    tick();
    iss_vld = 1'b0;
    n_chk++; if (busy !== 4'b0100) $display("FAIL single_claim_busy got=%b exp=0100", busy); else n_pass++;
    alu_vld = 1'b1; alu_rd = 2'd2; alu_data = 16'hBEEF; #1;
    n_chk++; if (alu_rdy !== 1'b1) $display("FAIL single_alu_rdy got=%b exp=1", alu_rdy); else n_pass++;
    tick();
    alu_vld = 1'b0;
    n_chk++; if (wb_en !== 1'b0) $display("FAIL single_lat_n got=%b exp=0", wb_en); else n_pass++;
    tick();
    n_chk++; if (wb_en !== 1'b1) $display("FAIL single_wb_en got=%b exp=1", wb_en); else n_pass++;
    n_chk++; if (wb_rd !== 2'd2) $display("FAIL single_wb_rd got=%h exp=2", wb_rd); else n_pass++;
    n_chk++; if (wb_data !== 16'hBEEF) $display("FAIL single_wb_data got=%h exp=beef", wb_data); else n_pass++;
    n_chk++; if (busy !== 4'b0100) $display("FAIL single_busy_n1 got=%b exp=0100", busy); else n_pass++;
    tick();
    n_chk++; if (wb_en !== 1'b0) $display("FAIL single_pulse got=%b exp=0", wb_en); else n_pass++;
    n_chk++; if (busy !== 4'b0000) $display("FAIL single_busy_n2 got=%b exp=0000", busy); else n_pass++;
    n_chk++; if (wb_data !== 16'hBEEF) $display("FAIL single_hold got=%h exp=beef", wb_data); else n_pass++;
  endtask

  task automatic test_contention();
    logic [17:0] exp_c [4];
    exp_c = '{18'h0A000, 18'h1B001, 18'h0A002, 18'h1B003};
    log_q.delete();
    alu_vld = 1'b1; ld_vld = 1'b1; alu_rd = 2'd0; ld_rd = 2'd1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 16'(16'hA000 + i);
      ld_data  = 16'(16'hB000 + i);
      #1;
      n_chk++; if ({alu_rdy, ld_rdy} !== (((i % 2) == 0) ? 2'b10 : 2'b01))
        $display("FAIL cont_grant[%0d] got=%b exp=%b", i, {alu_rdy, ld_rdy}, (((i % 2) == 0) ? 2'b10 : 2'b01));
      else n_pass++;
      tick();
    end
    idle();
    tick(); tick(); tick(); tick();
    n_chk++; if (log_q.size() != 4) $display("FAIL cont_count got=%0d exp=4", log_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= log_q.size()) $display("FAIL cont_order[%0d] got=none exp=%h", i, exp_c[i]);
      else if (log_q[i] !== exp_c[i]) $display("FAIL cont_order[%0d] got=%h exp=%h", i, log_q[i], exp_c[i]);
      else n_pass++;
    end
    n_chk++; if (busy !== 4'b0000) $display("FAIL cont_no_underflow got=%b exp=0000", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_b [5];
    exp_b = '{18'h3C000, 18'h2D001, 18'h3C002, 18'h2D003, 18'h3C004};
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      if ((i % 2) == 0) begin
        alu_vld = 1'b1; ld_vld = 1'b0; alu_rd = 2'd3; alu_data = 16'(16'hC000 + i);
      end else begin
        alu_vld = 1'b0; ld_vld = 1'b1; ld_rd = 2'd2; ld_data = 16'(16'hD000 + i);
      end
      #1;
      n_chk++; if ((alu_rdy | ld_rdy) !== 1'b1) $display("FAIL b2b_rdy[%0d] got=%b exp=1", i, alu_rdy | ld_rdy); else n_pass++;
      tick();
    end
    idle();
    tick(); tick(); tick(); tick();
    n_chk++; if (log_q.size() != 5) $display("FAIL b2b_count got=%0d exp=5", log_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= log_q.size()) $display("FAIL b2b_order[%0d] got=none exp=%h", i, exp_b[i]);
      else if (log_q[i] !== exp_b[i]) $display("FAIL b2b_order[%0d] got=%h exp=%h", i, log_q[i], exp_b[i]);
      else n_pass++;
    end
  endtask

  task automatic test_scoreboard_sat();
    iss_vld = 1'b1; iss_rd = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (iss_rdy !== 1'b1) $display("FAIL sb_claim_rdy[%0d] got=%b exp=1", k, iss_rdy); else n_pass++;
      tick();
    end
    n_chk++; if (iss_rdy !== 1'b0) $display("FAIL sb_sat_rdy got=%b exp=0", iss_rdy); else n_pass++;
    n_chk++; if (busy !== 4'b0010) $display("FAIL sb_sat_busy got=%b exp=0010", busy); else n_pass++;
    iss_vld = 1'b0;
    alu_vld = 1'b1; alu_rd = 2'd1; alu_data = 16'h1111;
    tick();
    alu_vld = 1'b0;
    tick();
    iss_vld = 1'b1; iss_rd = 2'd1; #1;
    n_chk++; if (iss_rdy !== 1'b1) $display("FAIL sb_bypass_rdy got=%b exp=1", iss_rdy); else n_pass++;
    tick();
    iss_vld = 1'b0;
    n_chk++; if (iss_rdy !== 1'b0) $display("FAIL sb_stays3_rdy got=%b exp=0", iss_rdy); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      alu_vld = 1'b1; alu_rd = 2'd1; alu_data = 16'(16'h2220 + k);
      tick();
    end
    alu_vld = 1'b0;
    tick();
    n_chk++; if (busy !== 4'b0010) $display("FAIL sb_drain_partial got=%b exp=0010", busy); else n_pass++;
    tick();
    n_chk++; if (busy !== 4'b0000) $display("FAIL sb_drain_done got=%b exp=0000", busy); else n_pass++;
  endtask

  task automatic test_claim_retire();
    iss_vld = 1'b1; iss_rd = 2'd3;
    tick();
    iss_vld = 1'b0;
    n_chk++; if (busy !== 4'b1000) $display("FAIL cr_claim_busy got=%b exp=1000", busy); else n_pass++;
    alu_vld = 1'b1; alu_rd = 2'd3; alu_data = 16'h3333;
    tick();
    alu_vld = 1'b0;
    tick();
    n_chk++; if ({wb_en, wb_rd} !== 3'b111) $display("FAIL cr_retire got=%b exp=111", {wb_en, wb_rd}); else n_pass++;
    iss_vld = 1'b1; iss_rd = 2'd3; #1;
    n_chk++; if (iss_rdy !== 1'b1) $display("FAIL cr_rdy got=%b exp=1", iss_rdy); else n_pass++;
    tick();
    iss_vld = 1'b0;
    n_chk++; if (busy !== 4'b1000) $display("FAIL cr_busy_held got=%b exp=1000", busy); else n_pass++;
    alu_vld = 1'b1; alu_rd = 2'd3; alu_data = 16'h4444;
    tick();
    alu_vld = 1'b0;
    tick();
    n_chk++; if (busy !== 4'b1000) $display("FAIL cr_busy_pre got=%b exp=1000", busy); else n_pass++;
    tick();
    n_chk++; if (busy !== 4'b0000) $display("FAIL cr_busy_clear got=%b exp=0000", busy); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    alu_vld = 1'b0; ld_vld = 1'b0; iss_vld = 1'b0;
    alu_rd = '0; ld_rd = '0; iss_rd = '0;
    alu_data = '0; ld_data = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_scoreboard_sat();
    test_claim_retire();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
